// File: rtl/inv_key_schedule.sv
// Inverse AES-128 key schedule: emits round keys 10 down to 0 over a valid/ready handshake.
// Build option INV_KEY_EQUIV_DEC_EN presents rounds 1..9 as InvMixColumns(key) for the equivalent inverse cipher.
module inv_key_schedule (
    input  logic         CLOCK_50,
    input  logic         reset_n,
    input  logic         start,
    input  logic [127:0] last_key,
    input  logic         out_ready,
    output logic         out_valid,
    output logic [127:0] round_key,
    output logic [3:0]   key_round,
    output logic         busy,
    output logic         done
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] EMIT   = 2'd1;
    localparam logic [1:0] FINISH = 2'd2;

    // Forward AES S-box, entry 0x00 in the most significant byte.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_TABLE[{~b, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    // Undo one forward expansion step: round r words {W4..W7} -> round r-1 words {W0..W3}.
    function automatic logic [127:0] prev_key(input logic [127:0] k, input logic [3:0] r);
        logic [31:0] w4, w5, w6, w7, w0p, w1p, w2p, w3p, rot;
        w4  = k[127:96];
        w5  = k[95:64];
        w6  = k[63:32];
        w7  = k[31:0];
        w3p = w7 ^ w6;
        w2p = w6 ^ w5;
        w1p = w5 ^ w4;
        rot = {w3p[23:0], w3p[31:24]};
        w0p = w4 ^ {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])}
                 ^ {rcon(r), 24'h000000};
        return {w0p, w1p, w2p, w3p};
    endfunction

`ifdef INV_KEY_EQUIV_DEC_EN
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Returns {0e*s, 0b*s, 0d*s, 09*s} in GF(2^8).
    function automatic logic [31:0] inv_mul(input logic [7:0] s);
        logic [7:0] s2, s4, s8;
        s2 = xtime(s);
        s4 = xtime(s2);
        s8 = xtime(s4);
        return {s8 ^ s4 ^ s2, s8 ^ s2 ^ s, s8 ^ s4 ^ s, s8 ^ s};
    endfunction

    function automatic logic [31:0] inv_mix_word(input logic [31:0] w);
        logic [31:0] a0, a1, a2, a3;
        a0 = inv_mul(w[31:24]);
        a1 = inv_mul(w[23:16]);
        a2 = inv_mul(w[15:8]);
        a3 = inv_mul(w[7:0]);
        return {a0[31:24] ^ a1[23:16] ^ a2[15:8]  ^ a3[7:0],
                a0[7:0]   ^ a1[31:24] ^ a2[23:16] ^ a3[15:8],
                a0[15:8]  ^ a1[7:0]   ^ a2[31:24] ^ a3[23:16],
                a0[23:16] ^ a1[15:8]  ^ a2[7:0]   ^ a3[31:24]};
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] k);
        return {inv_mix_word(k[127:96]), inv_mix_word(k[95:64]),
                inv_mix_word(k[63:32]),  inv_mix_word(k[31:0])};
    endfunction
`endif

    logic [1:0]   state_r, state_s;
    logic [127:0] raw_key_r, raw_key_s;
    logic [3:0]   key_round_r, key_round_s;
    logic         out_valid_r, busy_r, done_r;

    // Next state, next raw key and next round index.
    always_comb begin
        state_s     = state_r;
        raw_key_s   = raw_key_r;
        key_round_s = key_round_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_s     = EMIT;
                    raw_key_s   = last_key;
                    key_round_s = 4'd10;
                end else begin
                    state_s     = IDLE;
                end
            end
            EMIT: begin
                if (out_ready) begin
                    if (key_round_r == 4'd0) begin
                        state_s = FINISH;
                    end else begin
                        raw_key_s   = prev_key(raw_key_r, key_round_r);
                        key_round_s = key_round_r - 4'd1;
                    end
                end else begin
                    state_s = EMIT;
                end
            end
            FINISH:  state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // State, key and status registers; status flags decoded from the next state.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= IDLE;
            raw_key_r   <= 128'd0;
            key_round_r <= 4'd0;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            raw_key_r   <= raw_key_s;
            key_round_r <= key_round_s;
            out_valid_r <= (state_s == EMIT);
            busy_r      <= (state_s != IDLE);
            done_r      <= (state_s == FINISH);
        end
    end

`ifdef INV_KEY_EQUIV_DEC_EN
    logic [127:0] out_key_r;

    // Output copy of the key; rounds 1..9 transformed, recurrence above stays on raw keys.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            out_key_r <= 128'd0;
        end else begin
            out_key_r <= (key_round_s != 4'd0 && key_round_s != 4'd10) ?
                         inv_mix_columns(raw_key_s) : raw_key_s;
        end
    end

    assign round_key = out_key_r;
`else
    assign round_key = raw_key_r;
`endif

    assign out_valid = out_valid_r;
    assign key_round = key_round_r;
    assign busy      = busy_r;
    assign done      = done_r;

endmodule

// File: tb/tb_inv_key_schedule.sv
// Self-checking bench for inv_key_schedule: FIPS-197 key table, scoreboard, stall/start/reset corners.
module tb_inv_key_schedule;

    logic         CLOCK_50 = 1'b0;
    logic         reset_n;
    logic         start;
    logic [127:0] last_key;
    logic         out_ready;
    logic         out_valid;
    logic [127:0] round_key;
    logic [3:0]   key_round;
    logic         busy;
    logic         done;

    always #10 CLOCK_50 = ~CLOCK_50;

    inv_key_schedule dut (
        .CLOCK_50  (CLOCK_50),
        .reset_n   (reset_n),
        .start     (start),
        .last_key  (last_key),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .round_key (round_key),
        .key_round (key_round),
        .busy      (busy),
        .done      (done)
    );

    typedef struct {
        logic [3:0]   rnd;
        logic [127:0] key;
    } vec_t;

    typedef struct {
        bit toggle;
        bit inject;
        int emit_cycles;
    } scen_t;

    localparam logic [127:0] FIPS_LAST = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] JUNK_KEY  = 128'h00112233445566778899aabbccddeeff;

    vec_t         kt [11];
    scen_t        sc [3];
    int           checks = 0;
    int           errors = 0;
    logic [131:0] sb_q [$];
    logic         prev_stall = 1'b0;
    logic [131:0] prev_out = 132'd0;
    int           emit_n;
    int           gap_n;
    bit           seen;

    task automatic check(input string name, input logic [131:0] act, input logic [131:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

`ifdef INV_KEY_EQUIV_DEC_EN
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p  = 8'h00;
        logic [7:0] aa = a;
        logic [7:0] bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1b) : {aa[6:0], 1'b0};
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [127:0] ref_inv_mix(input logic [127:0] k);
        logic [127:0] r;
        logic [7:0]   s0, s1, s2, s3;
        r = 128'd0;
        for (int c = 0; c < 4; c++) begin
            s0 = k[127-32*c -: 8];
            s1 = k[119-32*c -: 8];
            s2 = k[111-32*c -: 8];
            s3 = k[103-32*c -: 8];
            r[127-32*c -: 8] = gmul(s0, 8'h0e) ^ gmul(s1, 8'h0b) ^ gmul(s2, 8'h0d) ^ gmul(s3, 8'h09);
            r[119-32*c -: 8] = gmul(s0, 8'h09) ^ gmul(s1, 8'h0e) ^ gmul(s2, 8'h0b) ^ gmul(s3, 8'h0d);
            r[111-32*c -: 8] = gmul(s0, 8'h0d) ^ gmul(s1, 8'h09) ^ gmul(s2, 8'h0e) ^ gmul(s3, 8'h0b);
            r[103-32*c -: 8] = gmul(s0, 8'h0b) ^ gmul(s1, 8'h0d) ^ gmul(s2, 8'h09) ^ gmul(s3, 8'h0e);
        end
        return r;
    endfunction
`endif

    task automatic push_expected();
        logic [127:0] k;
        for (int i = 0; i < 11; i++) begin
            k = kt[i].key;
`ifdef INV_KEY_EQUIV_DEC_EN
            if (kt[i].rnd != 4'd0 && kt[i].rnd != 4'd10) k = ref_inv_mix(k);
`endif
            sb_q.push_back({kt[i].rnd, k});
        end
    endtask

    // Scoreboard consumer plus hold check for stalled outputs.
    always @(negedge CLOCK_50) begin
        if (!reset_n) begin
            prev_stall <= 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", 132'(out_valid), 132'd1);
                check("hold_key", {key_round, round_key}, prev_out);
            end
            if (out_valid && out_ready) begin
                if (sb_q.size() > 0) begin
                    check("sb_key", {key_round, round_key}, sb_q[0]);
                    sb_q.delete(0);
                end else begin
                    check("sb_underflow", 132'(sb_q.size()), 132'd1);
                end
            end
            prev_stall <= out_valid && !out_ready;
            prev_out   <= {key_round, round_key};
        end
    end

    task automatic accept_start(input bit toggle);
        start    = 1'b1;
        last_key = FIPS_LAST;
        push_expected();
        @(posedge CLOCK_50); #1;
        start     = 1'b0;
        last_key  = 128'd0;
        out_ready = toggle ? 1'b0 : 1'b1;
    endtask

    // Runs until done is seen (returns on the negedge of the done cycle) or the budget expires.
    task automatic drain(input bit toggle, input bit inject, output int emit_cyc,
                         output int gap, output bit got_done);
        int hs0 = -100;
        emit_cyc = 0;
        gap      = -1;
        got_done = 1'b0;
        for (int cyc = 0; cyc < 64; cyc++) begin
            @(negedge CLOCK_50);
            if (out_valid) emit_cyc++;
            if (out_valid && out_ready && key_round == 4'd0) hs0 = cyc;
            if (done) begin
                got_done = 1'b1;
                gap      = cyc - hs0;
                break;
            end
            @(posedge CLOCK_50); #1;
            if (toggle) out_ready = ~out_ready;
            if (inject && out_valid && key_round == 4'd5) begin
                start    = 1'b1;
                last_key = JUNK_KEY;
            end else begin
                start = 1'b0;
            end
        end
    endtask

    task automatic check_run(input string tag, input int exp_emit);
        check({tag, "_done_seen"}, 132'(seen), 132'd1);
        check({tag, "_emit_cycles"}, 132'(emit_n), 132'(exp_emit));
        check({tag, "_done_gap"}, 132'(gap_n), 132'd1);
        check({tag, "_sb_drained"}, 132'(sb_q.size()), 132'd0);
    endtask

    initial begin
        kt[0]  = '{4'd10, FIPS_LAST};
        kt[1]  = '{4'd9,  128'hac7766f319fadc2128d12941575c006e};
        kt[2]  = '{4'd8,  128'head27321b58dbad2312bf5607f8d292f};
        kt[3]  = '{4'd7,  128'h4e54f70e5f5fc9f384a64fb24ea6dc4f};
        kt[4]  = '{4'd6,  128'h6d88a37a110b3efddbf98641ca0093fd};
        kt[5]  = '{4'd5,  128'hd4d1c6f87c839d87caf2b8bc11f915bc};
        kt[6]  = '{4'd4,  128'hef44a541a8525b7fb671253bdb0bad00};
        kt[7]  = '{4'd3,  128'h3d80477d4716fe3e1e237e446d7a883b};
        kt[8]  = '{4'd2,  128'hf2c295f27a96b9435935807a7359f67f};
        kt[9]  = '{4'd1,  128'ha0fafe1788542cb123a339392a6c7605};
        kt[10] = '{4'd0,  128'h2b7e151628aed2a6abf7158809cf4f3c};
        sc[0]  = '{1'b0, 1'b0, 11};
        sc[1]  = '{1'b1, 1'b0, 22};
        sc[2]  = '{1'b0, 1'b1, 11};

        reset_n   = 1'b0;
        start     = 1'b0;
        last_key  = 128'd0;
        out_ready = 1'b0;
        #5;
        check("reset_valid", 132'(out_valid), 132'd0);
        check("reset_busy", 132'(busy), 132'd0);
        check("reset_done", 132'(done), 132'd0);
        check("reset_key", {key_round, round_key}, 132'd0);
        #20 reset_n = 1'b1;
        @(posedge CLOCK_50); #1;

        // Table of scenarios: ready high, ready toggling, stray start at round 5.
        for (int i = 0; i < 3; i++) begin
            accept_start(sc[i].toggle);
            drain(sc[i].toggle, sc[i].inject, emit_n, gap_n, seen);
            check_run($sformatf("scen%0d", i), sc[i].emit_cycles);
            check("finish_busy_valid", 132'({busy, out_valid}), 132'b10);
            @(negedge CLOCK_50);
            check("idle_after_done", 132'({busy, done, out_valid}), 132'd0);
        end

        // start held through the done cycle: ignored in FINISH, taken in the following IDLE.
        accept_start(1'b0);
        drain(1'b0, 1'b0, emit_n, gap_n, seen);
        check_run("pre_finish", 11);
        start    = 1'b1;
        last_key = FIPS_LAST;
        @(negedge CLOCK_50);
        check("finish_start_ignored", 132'({busy, out_valid}), 132'd0);
        push_expected();
        @(posedge CLOCK_50); #1;
        start = 1'b0;
        check("idle_start_taken", {115'd0, out_valid, key_round, 12'd0}, {115'd1, 4'd10, 12'd0});
        drain(1'b0, 1'b0, emit_n, gap_n, seen);
        check_run("post_finish", 11);
        @(negedge CLOCK_50);

        // Asynchronous reset in the middle of a schedule.
        accept_start(1'b0);
        for (int c = 0; c < 16; c++) begin
            if (key_round == 4'd6) break;
            @(posedge CLOCK_50); #1;
        end
        check("reach_round6", 132'(key_round), 132'd6);
        #2 reset_n = 1'b0;
        #1;
        check("abort_valid_busy_done", 132'({out_valid, busy, done}), 132'd0);
        check("abort_key", {key_round, round_key}, 132'd0);
        sb_q.delete();
        #25 reset_n = 1'b1;
        repeat (3) @(negedge CLOCK_50);
        check("wait_new_start", 132'({busy, out_valid}), 132'd0);
        accept_start(1'b0);
        drain(1'b0, 1'b0, emit_n, gap_n, seen);
        check_run("after_reset", 11);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
